// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the sequential radix-4 Booth multiplier
// Contents: FSM state enum, Booth operation encoding, iteration-count helpers.
package mult_pkg;
  localparam int DEF_W = 32;
  localparam int ITER = DEF_W / 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {ZERO, ADD1, ADD2, SUB1, SUB2} booth_op_e;
  function automatic int iter_of(input int w);
    return w / 2;
  endfunction
  // Radix-4 Booth recoding of {mplier[1:0], q_m1}
  function automatic booth_op_e booth_recode(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return ADD1;
      3'b011:         return ADD2;
      3'b100:         return SUB2;
      3'b101, 3'b110: return SUB1;
      default:        return ZERO;
    endcase
  endfunction
endpackage

// File: rtl/cla_adder.sv
// cla_adder: parallel-prefix carry-lookahead adder with carry-in
// Ports: a, b (WIDTH) addends; cin carry-in; sum (WIDTH) result, carry-out dropped.
module cla_adder #(
  parameter int WIDTH = 34
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);
  localparam int LV = $clog2(WIDTH);
  logic [WIDTH-1:0] gs, ps, gn, pn, c;
  // Per-bit AND-generate / OR-propagate combined in log2(WIDTH) prefix levels;
  // afterwards gs[i]/ps[i] are the group terms spanning bits 0..i.
  always_comb begin
    gs = a & b;
    ps = a | b;
    gn = '0;
    pn = '0;
    for (int k = 0; k < LV; k++) begin
      gn = gs | (ps & (gs << (1 << k)));
      pn = ps & ((ps << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
      gs = gn;
      ps = pn;
    end
    c = {gs[WIDTH-2:0] | (ps[WIDTH-2:0] & {(WIDTH-1){cin}}), cin};
    sum = a ^ b ^ c;
  end
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth signed multiplier, DATA_W/2 iterations
// Ports: clock, reset_n (async active-low); ctrl_MULT start pulse sampling
//   data_operandA/B; data_result low DATA_W product bits; data_exception signed
//   overflow; data_resultRDY one-cycle done pulse; busy while iterating.
// Build option: define MULT_OVF_EN to compile in overflow detection, otherwise
//   data_exception is tied low.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_MULT,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);
  localparam int AW = DATA_W + 2;
  localparam int IT = iter_of(DATA_W);
  localparam int CW = IT > 1 ? $clog2(IT) : 1;
  state_e state, nxt;
  booth_op_e op;
  logic [AW-1:0] mcand, acc, term, opb, sum;
  logic [DATA_W-1:0] mplier;
  logic q_m1, neg, last;
  logic [CW-1:0] cnt;
  assign op = booth_recode({mplier[1:0], q_m1});
  assign last = cnt == CW'(IT - 1);
  assign busy = state == RUN;
  always_comb begin
    term = op == ADD2 || op == SUB2 ? {mcand[AW-2:0], 1'b0} : op == ZERO ? '0 : mcand;
    neg = op == SUB1 || op == SUB2;
    opb = neg ? ~term : term;
  end
  cla_adder #(.WIDTH(AW)) u_add (
    .a  (acc),
    .b  (opb),
    .cin(neg),
    .sum(sum)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // A start in any state (re)loads the operands; aborted runs never reach DONE.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ctrl_MULT ? RUN : IDLE;
      RUN:     nxt = ctrl_MULT ? RUN : last ? DONE : RUN;
      DONE:    nxt = ctrl_MULT ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
      q_m1 <= 1'b0;
      cnt <= '0;
    end else if (ctrl_MULT) begin
      mcand <= {{2{data_operandA[DATA_W-1]}}, data_operandA};
      acc <= '0;
      mplier <= data_operandB;
      q_m1 <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      // Arithmetic shift of {acc, mplier, q_m1} by two after the add
      acc <= {{2{sum[AW-1]}}, sum[AW-1:2]};
      mplier <= {sum[1:0], mplier[DATA_W-1:2]};
      q_m1 <= mplier[1];
      cnt <= cnt + 1'b1;
    end
  // Final product is {acc[DATA_W-1:0], mplier}; the low half is mplier.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      data_result <= '0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= state == DONE;
      if (state == DONE) data_result <= mplier;
    end
`ifdef MULT_OVF_EN
  logic [DATA_W:0] hi;
  assign hi = {acc[DATA_W-1:0], mplier[DATA_W-1]};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) data_exception <= 1'b0;
    else if (state == DONE) data_exception <= !(&hi || !(|hi));
`else
  assign data_exception = 1'b0;
`endif
endmodule
